// File: rtl/gray_pkg.sv
// Shared constants and types for the RGB-to-gray stream converter.
// Optional threshold output is enabled with the GRAY_THRESH_EN macro.
package gray_pkg;

  // Coefficient mode encodings; encoding 3 is reserved and behaves as BT.601.
  localparam logic [1:0] MODE_BT601 = 2'd0;
  localparam logic [1:0] MODE_BT709 = 2'd1;
  localparam logic [1:0] MODE_AVG   = 2'd2;

  // Coefficients are unsigned Q0.8 and each set sums to 256.
  localparam int COEF_FRAC_W = 8;
  localparam int ROUND_C     = 128;

  localparam logic [COEF_FRAC_W-1:0] C601_R = 8'd77;
  localparam logic [COEF_FRAC_W-1:0] C601_G = 8'd150;
  localparam logic [COEF_FRAC_W-1:0] C601_B = 8'd29;

  localparam logic [COEF_FRAC_W-1:0] C709_R = 8'd54;
  localparam logic [COEF_FRAC_W-1:0] C709_G = 8'd183;
  localparam logic [COEF_FRAC_W-1:0] C709_B = 8'd19;

  localparam logic [COEF_FRAC_W-1:0] CAVG_R = 8'd85;
  localparam logic [COEF_FRAC_W-1:0] CAVG_G = 8'd86;
  localparam logic [COEF_FRAC_W-1:0] CAVG_B = 8'd85;

  typedef struct packed {
    logic [COEF_FRAC_W-1:0] r;
    logic [COEF_FRAC_W-1:0] g;
    logic [COEF_FRAC_W-1:0] b;
  } coef_t;

  // Folds the reserved encoding onto BT.601 so only legal modes are stored.
  function automatic logic [1:0] mode_fix(input logic [1:0] m);
    return (m == 2'd3) ? MODE_BT601 : m;
  endfunction

  function automatic coef_t coef_of(input logic [1:0] m);
    coef_t c;
    case (m)
      MODE_BT709: c = '{r: C709_R, g: C709_G, b: C709_B};
      MODE_AVG:   c = '{r: CAVG_R, g: CAVG_G, b: CAVG_B};
      default:    c = '{r: C601_R, g: C601_G, b: C601_B};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gray_lane.sv
// One pixel lane: register inputs, multiply, sum/round/saturate.
// Fixed 3-cycle latency. GRAY_THRESH_EN adds a registered gray>=thresh bit.
module gray_lane
  import gray_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] r_i,
  input  logic [DATA_W-1:0] g_i,
  input  logic [DATA_W-1:0] b_i,
  input  coef_t             coef_i,
`ifdef GRAY_THRESH_EN
  input  logic [DATA_W-1:0] thresh_i,
  output logic              bin_o,
`endif
  output logic [DATA_W-1:0] gray_o
);

  localparam int PROD_W = DATA_W + COEF_FRAC_W;
  localparam int SUM_W  = DATA_W + COEF_FRAC_W + 2;

  logic [DATA_W-1:0] r1_q, g1_q, b1_q;
  coef_t             coef1_q;
  logic [PROD_W-1:0] pr2_d, pg2_d, pb2_d;
  logic [PROD_W-1:0] pr2_q, pg2_q, pb2_q;
  logic [SUM_W-1:0]  sum3_d, shr3_d;
  logic [DATA_W-1:0] gray3_d, gray3_q;

  // S1: capture components together with the coefficient set they belong to
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      coef1_q <= '0;
    end else begin
      r1_q    <= r_i;
      g1_q    <= g_i;
      b1_q    <= b_i;
      coef1_q <= coef_i;
    end
  end

  // S2 next state: three full-width products
  always_comb begin
    pr2_d = PROD_W'(r1_q) * PROD_W'(coef1_q.r);
    pg2_d = PROD_W'(g1_q) * PROD_W'(coef1_q.g);
    pb2_d = PROD_W'(b1_q) * PROD_W'(coef1_q.b);
  end

  // S2: register the products
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pr2_q <= '0;
      pg2_q <= '0;
      pb2_q <= '0;
    end else begin
      pr2_q <= pr2_d;
      pg2_q <= pg2_d;
      pb2_q <= pb2_d;
    end
  end

  // S3 next state: round to nearest, drop the fraction, clamp to full scale
  always_comb begin
    sum3_d  = SUM_W'(pr2_q) + SUM_W'(pg2_q) + SUM_W'(pb2_q) + SUM_W'(ROUND_C);
    shr3_d  = sum3_d >> COEF_FRAC_W;
    gray3_d = (|shr3_d[SUM_W-1:DATA_W]) ? '1 : shr3_d[DATA_W-1:0];
  end

  // S3: register the gray sample
  always_ff @(posedge clk_i) begin
    if (rst_i) gray3_q <= '0;
    else       gray3_q <= gray3_d;
  end

  assign gray_o = gray3_q;

`ifdef GRAY_THRESH_EN
  logic [DATA_W-1:0] t1_q, t2_q;
  logic              bin3_q;

  // Threshold travels with its pixel so a frame-boundary change stays aligned
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t1_q   <= '0;
      t2_q   <= '0;
      bin3_q <= 1'b0;
    end else begin
      t1_q   <= thresh_i;
      t2_q   <= t1_q;
      bin3_q <= (gray3_d >= t2_q);
    end
  end

  assign bin_o = bin3_q;
`endif

endmodule

// File: rtl/rgb2gray_stream.sv
// Multi-lane RGB-to-gray converter with delay-matched syncs and
// line/frame geometry counters. Optional binarised output: GRAY_THRESH_EN.
module rgb2gray_stream
  import gray_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter int         PIXELS   = 1,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] DEF_MODE = 2'd0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [1:0]                   mode,
`ifdef GRAY_THRESH_EN
  input  logic [DATA_W-1:0]            thresh,
`endif
  input  logic                         vid_in_active,
  input  logic                         vid_in_hsync,
  input  logic                         vid_in_vsync,
  input  logic [3*DATA_W*PIXELS-1:0]   vid_in_rgb,
  output logic                         vid_out_active,
  output logic                         vid_out_hsync,
  output logic                         vid_out_vsync,
  output logic [DATA_W*PIXELS-1:0]     vid_out_gray,
`ifdef GRAY_THRESH_EN
  output logic [PIXELS-1:0]            vid_out_bin,
`endif
  output logic [CNT_W-1:0]             stat_line_len,
  output logic                         stat_line_stb,
  output logic [CNT_W-1:0]             stat_frame_lines,
  output logic                         stat_frame_stb
);

  localparam int LAT = 3;

  logic       vs_prev_q, act_prev_q;
  logic       vs_rise, act_fall;
  logic [1:0] mode_q, mode_eff;
  coef_t      coef_eff;

  assign vs_rise  = vid_in_vsync & ~vs_prev_q;
  assign act_fall = act_prev_q & ~vid_in_active;

  // A new frame's settings apply from the vsync-rise cycle itself
  assign mode_eff = vs_rise ? mode_fix(mode) : mode_q;
  assign coef_eff = coef_of(mode_eff);

  // Edge-detect history for vsync and active
  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_prev_q  <= 1'b0;
      act_prev_q <= 1'b0;
    end else begin
      vs_prev_q  <= vid_in_vsync;
      act_prev_q <= vid_in_active;
    end
  end

  // Frame-safe mode register: only reloads on the vsync rising edge
  always_ff @(posedge CLK) begin
    if (RST)          mode_q <= mode_fix(DEF_MODE);
    else if (vs_rise) mode_q <= mode_fix(mode);
  end

`ifdef GRAY_THRESH_EN
  logic [DATA_W-1:0] thresh_q, thresh_eff;
  logic [PIXELS-1:0] lane_bin;

  assign thresh_eff = vs_rise ? thresh : thresh_q;

  // Threshold is latched alongside the mode
  always_ff @(posedge CLK) begin
    if (RST)          thresh_q <= '0;
    else if (vs_rise) thresh_q <= thresh;
  end
`endif

  logic [PIXELS-1:0][DATA_W-1:0] lane_gray;

  for (genvar k = 0; k < PIXELS; k++) begin : g_lane
    gray_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_i    (CLK),
      .rst_i    (RST),
      .r_i      (vid_in_rgb[3*DATA_W*k + 2*DATA_W +: DATA_W]),
      .g_i      (vid_in_rgb[3*DATA_W*k +   DATA_W +: DATA_W]),
      .b_i      (vid_in_rgb[3*DATA_W*k            +: DATA_W]),
      .coef_i   (coef_eff),
`ifdef GRAY_THRESH_EN
      .thresh_i (thresh_eff),
      .bin_o    (lane_bin[k]),
`endif
      .gray_o   (lane_gray[k])
    );
  end

  logic [LAT-1:0] act_pipe_q, hs_pipe_q, vs_pipe_q;

  // Sync delay lines matched to the lane latency
  always_ff @(posedge CLK) begin
    if (RST) begin
      act_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
    end else begin
      act_pipe_q <= {act_pipe_q[LAT-2:0], vid_in_active};
      hs_pipe_q  <= {hs_pipe_q[LAT-2:0],  vid_in_hsync};
      vs_pipe_q  <= {vs_pipe_q[LAT-2:0],  vid_in_vsync};
    end
  end

  assign vid_out_active = act_pipe_q[LAT-1];
  assign vid_out_hsync  = hs_pipe_q[LAT-1];
  assign vid_out_vsync  = vs_pipe_q[LAT-1];
  assign vid_out_gray   = vid_out_active ? lane_gray : '0;
`ifdef GRAY_THRESH_EN
  assign vid_out_bin    = lane_bin & {PIXELS{vid_out_active}};
`endif

  // Geometry counters, all saturating
  logic [CNT_W-1:0] line_cnt_q, line_len_q, lines_q, frame_lines_q;
  logic             line_stb_q, frame_stb_q;
  logic [CNT_W:0]   cnt_sum, lines_sum;
  logic [CNT_W-1:0] cnt_inc, lines_inc;

  always_comb begin
    cnt_sum   = {1'b0, line_cnt_q} + (CNT_W+1)'(PIXELS);
    cnt_inc   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    lines_sum = {1'b0, lines_q} + (CNT_W+1)'(1);
    lines_inc = lines_sum[CNT_W] ? '1 : lines_sum[CNT_W-1:0];
  end

  // Line length: count pixels per active run, publish on active fall
  always_ff @(posedge CLK) begin
    if (RST) begin
      line_cnt_q <= '0;
      line_len_q <= '0;
      line_stb_q <= 1'b0;
    end else begin
      line_stb_q <= 1'b0;
      if (act_fall) begin
        line_len_q <= line_cnt_q;
        line_stb_q <= 1'b1;
        line_cnt_q <= '0;
      end else if (vid_in_active) begin
        line_cnt_q <= cnt_inc;
      end
    end
  end

  // Frame lines: a line ending on the vsync-rise cycle closes into this frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      lines_q       <= '0;
      frame_lines_q <= '0;
      frame_stb_q   <= 1'b0;
    end else begin
      frame_stb_q <= 1'b0;
      if (vs_rise) begin
        frame_lines_q <= act_fall ? lines_inc : lines_q;
        frame_stb_q   <= 1'b1;
        lines_q       <= '0;
      end else if (act_fall) begin
        lines_q <= lines_inc;
      end
    end
  end

  assign stat_line_len    = line_len_q;
  assign stat_line_stb    = line_stb_q;
  assign stat_frame_lines = frame_lines_q;
  assign stat_frame_stb   = frame_stb_q;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Bench for rgb2gray_stream: one PIXELS=1 and one PIXELS=2 instance share
// stimulus (lane 0 common). Scoreboard queue checks data and syncs 3 cycles
// later; hand-written sequences cover stats, reset and frame-edge cases.
module tb_rgb2gray_stream;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  mode;
  logic        act, hs, vs;
  logic [23:0] rgb0, rgb1;
  logic [7:0]  exp0, exp1;

  logic        o1_act, o1_hs, o1_vs, s1_lstb, s1_fstb;
  logic [7:0]  o1_gray;
  logic [15:0] s1_llen, s1_flines;
  logic        o2_act, o2_hs, o2_vs, s2_lstb, s2_fstb;
  logic [15:0] o2_gray;
  logic [15:0] s2_llen, s2_flines;
`ifdef GRAY_THRESH_EN
  logic [7:0]  thresh = 8'd128;
  logic        bin1;
  logic [1:0]  bin2;
`endif

  always #5 CLK = ~CLK;

  rgb2gray_stream #(.DATA_W(8), .PIXELS(1), .CNT_W(16), .DEF_MODE(2'd0)) u_dut1 (
    .CLK(CLK), .RST(RST), .mode(mode),
`ifdef GRAY_THRESH_EN
    .thresh(thresh), .vid_out_bin(bin1),
`endif
    .vid_in_active(act), .vid_in_hsync(hs), .vid_in_vsync(vs), .vid_in_rgb(rgb0),
    .vid_out_active(o1_act), .vid_out_hsync(o1_hs), .vid_out_vsync(o1_vs),
    .vid_out_gray(o1_gray),
    .stat_line_len(s1_llen), .stat_line_stb(s1_lstb),
    .stat_frame_lines(s1_flines), .stat_frame_stb(s1_fstb));

  rgb2gray_stream #(.DATA_W(8), .PIXELS(2), .CNT_W(16), .DEF_MODE(2'd0)) u_dut2 (
    .CLK(CLK), .RST(RST), .mode(mode),
`ifdef GRAY_THRESH_EN
    .thresh(thresh), .vid_out_bin(bin2),
`endif
    .vid_in_active(act), .vid_in_hsync(hs), .vid_in_vsync(vs), .vid_in_rgb({rgb1, rgb0}),
    .vid_out_active(o2_act), .vid_out_hsync(o2_hs), .vid_out_vsync(o2_vs),
    .vid_out_gray(o2_gray),
    .stat_line_len(s2_llen), .stat_line_stb(s2_lstb),
    .stat_frame_lines(s2_flines), .stat_frame_stb(s2_fstb));

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] rgb0;
    logic [7:0]  exp0;
    logic [23:0] rgb1;
    logic [7:0]  exp1;
  } vec_t;

  typedef struct {
    logic       act, hs, vs;
    logic [7:0] g0, g1;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int nl1, nl2, nf1, nf2;
  bit stat_chk = 1'b0;
  int exp_len, exp_frames;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  // One clock: push expectation at the edge, compare outputs at the falling edge
  task automatic step();
    exp_t e, x;
    @(posedge CLK);
    if (RST) sbq.delete();
    else begin
      e.act = act; e.hs = hs; e.vs = vs;
      e.g0 = act ? exp0 : 8'd0;
      e.g1 = act ? exp1 : 8'd0;
      sbq.push_back(e);
    end
    @(negedge CLK);
    if (sbq.size() == 3) begin
      x = sbq.pop_front();
      chk("sb_p1", 64'({o1_act, o1_hs, o1_vs, o1_gray}), 64'({x.act, x.hs, x.vs, x.g0}));
      chk("sb_p2", 64'({o2_act, o2_hs, o2_vs, o2_gray}), 64'({x.act, x.hs, x.vs, x.g1, x.g0}));
    end
    if (s1_lstb) begin nl1++; if (stat_chk) chk("line_len_p1", 64'(s1_llen), 64'(exp_len)); end
    if (s2_lstb) begin nl2++; if (stat_chk) chk("line_len_p2", 64'(s2_llen), 64'(2*exp_len)); end
    if (s1_fstb) begin nf1++; if (stat_chk) chk("frame_lines_p1", 64'(s1_flines), 64'(exp_frames)); end
    if (s2_fstb) begin nf2++; if (stat_chk) chk("frame_lines_p2", 64'(s2_flines), 64'(exp_frames)); end
  endtask

  task automatic px(input logic [23:0] a, input logic [7:0] ea,
                    input logic [23:0] b, input logic [7:0] eb);
    act = 1'b1; rgb0 = a; exp0 = ea; rgb1 = b; exp1 = eb;
    step();
  endtask

  task automatic idle(input int n);
    act = 1'b0; exp0 = 8'd0; exp1 = 8'd0;
    repeat (n) step();
  endtask

  task automatic vpulse();
    act = 1'b0; exp0 = 8'd0; exp1 = 8'd0; vs = 1'b1;
    step();
    vs = 1'b0;
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) px(24'hFFFFFF, 8'd255, 24'h000000, 8'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1; act = 1'b0; hs = 1'b0; vs = 1'b0;
    repeat (2) step();
    RST = 1'b0;
    nl1 = 0; nl2 = 0; nf1 = 0; nf2 = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_p1"}, 64'({o1_act, o1_hs, o1_vs, o1_gray, s1_llen, s1_lstb, s1_flines, s1_fstb}), 64'd0);
    chk({nm, "_p2"}, 64'({o2_act, o2_hs, o2_vs, o2_gray, s2_llen, s2_lstb, s2_flines, s2_fstb}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{2'd0, 24'hFF0000, 8'd77,  24'h00FF00, 8'd149};
    vecs[1] = '{2'd0, 24'h0000FF, 8'd29,  24'hFFFFFF, 8'd255};
    vecs[2] = '{2'd1, 24'hFF0000, 8'd54,  24'h00FF00, 8'd182};
    vecs[3] = '{2'd1, 24'h0000FF, 8'd19,  24'h804020, 8'd75};
    vecs[4] = '{2'd2, 24'hFF0000, 8'd85,  24'h00FF00, 8'd86};
    vecs[5] = '{2'd2, 24'h804020, 8'd75,  24'h000000, 8'd0};
    vecs[6] = '{2'd3, 24'hFF0000, 8'd77,  24'h804020, 8'd80};

    mode = 2'd0; rgb0 = '0; rgb1 = '0; exp0 = '0; exp1 = '0;
    do_reset();
    chk_zero("reset_state");

    // Ramp in default BT.601, hsync pattern to verify sync delay
    for (int i = 0; i < 26; i++) begin
      hs = (i % 4 == 0);
      px(24'(i) * 24'h0A0A0A, 8'(i * 10), 24'(25 - i) * 24'h0A0A0A, 8'((25 - i) * 10));
    end
    hs = 1'b0;
    idle(4);

    // Coefficient table, one frame per record
    for (int k = 0; k < 7; k++) begin
      mode = vecs[k].mode;
      vpulse();
      px(vecs[k].rgb0, vecs[k].exp0, vecs[k].rgb1, vecs[k].exp1);
      idle(2);
    end
    idle(3);

    // Mode change mid-frame only takes effect at the next vsync rise
    mode = 2'd0;
    vpulse();
    px(24'hFF0000, 8'd77, 24'h00FF00, 8'd149);
    mode = 2'd1;
    idle(1);
    px(24'hFF0000, 8'd77, 24'h00FF00, 8'd149);
    idle(2);
    vpulse();
    px(24'hFF0000, 8'd54, 24'h00FF00, 8'd182);
    idle(4);

`ifdef GRAY_THRESH_EN
    mode = 2'd0;
    vpulse();
    px(24'h7F7F7F, 8'd127, 24'h808080, 8'd128);
    idle(2);
    chk("thresh_p1", 64'(bin1), 64'd0);
    chk("thresh_p2", 64'(bin2), 64'b10);
    idle(1);
    chk("thresh_idle_p2", 64'(bin2), 64'd0);
    idle(3);
`endif

    // Geometry: 4 lines of 1280 beats then a vsync pulse
    do_reset();
    stat_chk = 1'b1; exp_len = 1280; exp_frames = 4;
    for (int l = 0; l < 4; l++) begin
      hs = 1'b1; idle(1); hs = 1'b0;
      idle(99);
      line(1280);
    end
    idle(10);
    vpulse();
    idle(5);
    chk("geom_lines_p1", 64'(nl1), 64'd4);
    chk("geom_lines_p2", 64'(nl2), 64'd4);
    chk("geom_frames_p1", 64'(nf1), 64'd1);
    chk("geom_frames_p2", 64'(nf2), 64'd1);

    // Active fall coincident with vsync rise counts into the closing frame
    nl1 = 0; nl2 = 0; nf1 = 0; nf2 = 0;
    exp_len = 10; exp_frames = 3;
    line(10); idle(5);
    line(10); idle(5);
    line(10);
    act = 1'b0; exp0 = 8'd0; exp1 = 8'd0; vs = 1'b1;
    step();
    chk("coinc_p1", 64'({s1_fstb, s1_flines, s1_lstb}), 64'({1'b1, 16'd3, 1'b1}));
    chk("coinc_p2", 64'({s2_fstb, s2_flines, s2_lstb}), 64'({1'b1, 16'd3, 1'b1}));
    vs = 1'b0;
    step();
    chk("stb_pulse_p1", 64'({s1_fstb, s1_lstb}), 64'd0);
    chk("stb_pulse_p2", 64'({s2_fstb, s2_lstb}), 64'd0);
    idle(3);
    chk("coinc_counts", 64'({8'(nl1), 8'(nl2), 8'(nf1), 8'(nf2)}), 64'({8'd3, 8'd3, 8'd1, 8'd1}));

    // Reset mid-line: outputs clear, aborted line never reported
    nl1 = 0; nl2 = 0; nf1 = 0; nf2 = 0;
    exp_len = 30;
    line(50);
    RST = 1'b1;
    step();
    chk_zero("midline_reset");
    RST = 1'b0;
    idle(5);
    line(30);
    idle(5);
    chk("post_reset_lines_p1", 64'(nl1), 64'd1);
    chk("post_reset_lines_p2", 64'(nl2), 64'd1);
    chk("post_reset_frames", 64'(nf1 + nf2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
